alu_responder: RTL
==================

# alu_responder

Pipelined request/response wrapper around the combinational `alu`. It accepts operand/opcode requests over a valid/ready channel, registers them, and evaluates them through one `alu` instance. Results and flags go into an in-order response queue drained over a second valid/ready channel. The block lets the CPU datapath, or a bus-attached test initiator, issue ALU operations at one per cycle while tolerating downstream backpressure.

## Interface
- `N`, 32: operand/result width (only 32 supported).
- `TAG_W`, 4: width of the opaque request tag returned with each response.
- `RSP_DEPTH`, 2: response queue entries (power of two, ≥2).

- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous clear of stage and queue.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_a`, `req_b` in N: operands.
- `req_op` in `alu_control_t`: operation, enumerated in `alu_types.sv`.
- `req_tag` in TAG_W: returned unchanged.
- `rsp_valid` out 1: queue head valid.
- `rsp_ready` in 1: head popped when `rsp_valid && rsp_ready` at a rising edge.
- `rsp_result` out N: ALU `out`.
- `rsp_overflow`, `rsp_zero`, `rsp_equal` out 1 each: ALU `overflow`, `outputs_zero`, `inputs_equal`.
- `rsp_tag` out TAG_W: tag of head entry.
- `stat_rsp_count` out 32: responses popped (see Configuration).
- `stat_ovf_count` out 32: popped responses with overflow=1.

## Operation
- Stage register holds `{a,b,op,tag}` plus `stage_valid`. The `alu` is driven only from stage registers, never from `req_*`.
- `advance = stage_valid && (count < RSP_DEPTH || pop)`, where `pop = rsp_valid && rsp_ready`.
- On `advance`, `{result, overflow, zero, equal, tag}` is written to the queue tail.
- `req_ready = !stage_valid || advance`. This is combinational from `rsp_ready`, which is intended.
- Accept loads the stage. `stage_valid` clears on `advance` without a same-edge accept.
- Queue: circular buffer with `wr_ptr`/`rd_ptr` wrapping modulo RSP_DEPTH and `count` in 0..RSP_DEPTH.
  - Push and pop on the same edge leave `count` unchanged, including when `count == RSP_DEPTH`.
- Responses leave strictly in acceptance order. Tags are never reordered or dropped.
- `flush`: `stage_valid`, `count`, and both pointers go to 0 on the next edge.
  - A request offered in the flush cycle is not accepted; `req_ready` is forced 0 while `flush` is high.
  - Stats counters are not cleared by flush.
- Unused `alu_control_t` encodings pass through to `alu`. Response contents are whatever `alu` produces.

## Timing
- Reset values:
  - `req_ready`=1 (once `rst_n` is high).
  - `rsp_valid`=0.
  - `rsp_result`=0, all flags 0, `rsp_tag`=0 (queue storage reset to 0).
  - Stats=0, `stage_valid`=0, pointers=0.
- Latency: accept at edge E0 → entry pushed at E1 → `rsp_valid`=1 in the cycle after E1. Minimum 2 edges request-to-response.
- Throughput: 1 request/cycle sustained while `rsp_ready`=1.
- Capacity with `rsp_ready` held 0: RSP_DEPTH+1 requests accepted, then `req_ready`=0.
- `rsp_*` data are stable while `rsp_valid && !rsp_ready`.
- `rst_n` asserted mid-operation: all in-flight work is discarded immediately (asynchronous). The first accept is possible at the first edge after deassertion.
- Simultaneous `flush` and `pop`: flush wins. The pop is not counted in stats.

## Configuration
- `ALU_RESPONDER_STATS_EN`
  - Defined: `stat_rsp_count` increments on each `pop`. `stat_ovf_count` increments on each `pop` with head overflow=1. Both wrap at 2^32.
  - Undefined: both ports are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- ADD, a=0x7FFFFFFF, b=0x00000001, tag=3 → result 0x80000000, overflow=1, zero=0, equal=0, tag=3, `rsp_valid` 2 edges after accept.
- SUB, a=b=0x00000005 → result 0, zero=1, equal=1, overflow=0.
- Backpressure: `rsp_ready`=0 while issuing tags 0..4 (RSP_DEPTH=2) → tags 0,1,2 accepted, `req_ready`=0. Raise `rsp_ready` → tags 0,1,2,3,4 returned in order, no gaps.
- Streaming: 64 random ops with `rsp_ready`=1 → one response per cycle after a 2-cycle fill. Every response matches `alu_behavioural` on the same inputs.
- Drop `rst_n` with 2 queued and 1 staged → `rsp_valid`=0 immediately. After release, a new ADD 1+1 returns 2 with no stale entries.
- With `ALU_RESPONDER_STATS_EN`: 10 pops, of which 3 overflowed → `stat_rsp_count`=10, `stat_ovf_count`=3. A flush with `pop` leaves both unchanged.

Source files
------------

// File: rtl/alu_responder.sv
// alu_responder: valid/ready wrapper staging requests through one alu into an in-order response queue.
// Rev 1.0. Optional response statistics are enabled by defining ALU_RESPONDER_STATS_EN.
`default_nettype none

package alu_types_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_control_t;
endpackage

module alu #(
  parameter int N = 32
) (
  input  logic [N-1:0]                in_a,
  input  logic [N-1:0]                in_b,
  input  alu_types_pkg::alu_control_t control,
  output logic [N-1:0]                out,
  output logic                        overflow,
  output logic                        outputs_zero,
  output logic                        inputs_equal
);
  import alu_types_pkg::*;

  logic [N-1:0] sum, diff;
  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (control)
      ALU_AND: out = in_a & in_b;
      ALU_OR:  out = in_a | in_b;
      ALU_ADD: begin
        out      = sum;
        overflow = (in_a[N-1] == in_b[N-1]) && (sum[N-1] != in_a[N-1]);
      end
      ALU_SUB: begin
        out      = diff;
        overflow = (in_a[N-1] != in_b[N-1]) && (diff[N-1] != in_a[N-1]);
      end
      ALU_SLT: out = {{(N-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_NOR: out = ~(in_a | in_b);
      default: out = '0;
    endcase
  end

  assign outputs_zero = (out == '0);
  assign inputs_equal = (in_a == in_b);
endmodule

module alu_responder #(
  parameter int N         = 32,
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [N-1:0]                req_a,
  input  logic [N-1:0]                req_b,
  input  alu_types_pkg::alu_control_t req_op,
  input  logic [TAG_W-1:0]            req_tag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [N-1:0]                rsp_result,
  output logic                        rsp_overflow,
  output logic                        rsp_zero,
  output logic                        rsp_equal,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [31:0]                 stat_rsp_count,
  output logic [31:0]                 stat_ovf_count
);
  import alu_types_pkg::*;

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic [N-1:0]     a_q, b_q;
  alu_control_t     op_q;
  logic [TAG_W-1:0] tag_q;
  logic             stage_valid_q, stage_valid_d;

  logic [N-1:0]     res_mem_q [RSP_DEPTH];
  logic [TAG_W-1:0] tag_mem_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] ovf_mem_q, zero_mem_q, eq_mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0] alu_out;
  logic         alu_ovf, alu_zero, alu_eq;
  logic         pop, advance, push, accept;

  alu #(.N(N)) u_alu (
    .in_a        (a_q),
    .in_b        (b_q),
    .control     (op_q),
    .out         (alu_out),
    .overflow    (alu_ovf),
    .outputs_zero(alu_zero),
    .inputs_equal(alu_eq)
  );

  assign rsp_valid    = (count_q != '0);
  assign rsp_result   = res_mem_q[rd_ptr_q];
  assign rsp_tag      = tag_mem_q[rd_ptr_q];
  assign rsp_overflow = ovf_mem_q[rd_ptr_q];
  assign rsp_zero     = zero_mem_q[rd_ptr_q];
  assign rsp_equal    = eq_mem_q[rd_ptr_q];

  // A pop frees a slot on the same edge, so a full queue still lets the stage drain.
  assign pop       = rsp_valid && rsp_ready;
  assign advance   = stage_valid_q && ((count_q < DEPTH_C) || pop);
  assign push      = advance && !flush;
  assign req_ready = !flush && (!stage_valid_q || advance);
  assign accept    = req_valid && req_ready;

  always_comb begin
    stage_valid_d = stage_valid_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (flush) begin
      stage_valid_d = 1'b0;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      if (accept)       stage_valid_d = 1'b1;
      else if (advance) stage_valid_d = 1'b0;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= ALU_AND;
      tag_q         <= '0;
      stage_valid_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ovf_mem_q     <= '0;
      zero_mem_q    <= '0;
      eq_mem_q      <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        res_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
    end else begin
      stage_valid_q <= stage_valid_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (accept) begin
        a_q   <= req_a;
        b_q   <= req_b;
        op_q  <= req_op;
        tag_q <= req_tag;
      end
      if (push) begin
        res_mem_q[wr_ptr_q]  <= alu_out;
        tag_mem_q[wr_ptr_q]  <= tag_q;
        ovf_mem_q[wr_ptr_q]  <= alu_ovf;
        zero_mem_q[wr_ptr_q] <= alu_zero;
        eq_mem_q[wr_ptr_q]   <= alu_eq;
      end
    end
  end

`ifdef ALU_RESPONDER_STATS_EN
  logic [31:0] stat_rsp_q, stat_ovf_q;

  // Flush takes precedence over a coincident pop, so that pop is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rsp_q <= '0;
      stat_ovf_q <= '0;
    end else if (pop && !flush) begin
      stat_rsp_q <= stat_rsp_q + 32'd1;
      if (rsp_overflow) stat_ovf_q <= stat_ovf_q + 32'd1;
    end
  end

  assign stat_rsp_count = stat_rsp_q;
  assign stat_ovf_count = stat_ovf_q;
`else
  assign stat_rsp_count = '0;
  assign stat_ovf_count = '0;
`endif
endmodule

`default_nettype wire
